// File: rtl/boot_hex_pkg.sv
// ============================================================================
// Package     : boot_hex_pkg
// Description : Shared definitions for the boot hex text path. Holds the
//               ASCII constants used by the formatter and parser, the
//               formatter state encoding, and a width helper.
// Contents    : CHAR_0, CHAR_A, CHAR_a, CHAR_SP, CHAR_CR, CHAR_LF,
//               fmt_state_e, clog2_min1()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_hex_pkg;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;
  localparam logic [7:0] CHAR_a  = 8'h61;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NIBBLE = 3'd1,
    ST_SPACE  = 3'd2,
    ST_CR     = 3'd3,
    ST_LF     = 3'd4
  } fmt_state_e;

  // Counter width for n distinct values, never below one bit so that
  // degenerate configurations (one nibble, one word per line) still
  // produce a legal vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_to_hex_char.sv
// ============================================================================
// Module      : nibble_to_hex_char
// Description : Combinational conversion of a 4-bit value to its ASCII hex
//               digit. Letter case for 10..15 is fixed by a parameter.
// Ports       : i_nibble  in  4           value to convert
//               o_char    out char_width  ASCII character
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_to_hex_char
  import boot_hex_pkg::*;
#(
  parameter int char_width = 8,
  parameter bit uppercase  = 1'b1
) (
  input  logic [3:0]            i_nibble,
  output logic [char_width-1:0] o_char
);

  localparam logic [7:0] c_LETTER_BASE = uppercase ? CHAR_A : CHAR_a;

  logic [7:0] w_ascii;

  always_comb begin
    w_ascii = CHAR_0;
    if (i_nibble < 4'd10) begin
      w_ascii = CHAR_0 + {4'h0, i_nibble};
    end else begin
      w_ascii = c_LETTER_BASE + {4'h0, i_nibble} - 8'd10;
    end
  end

  // ASCII is 7-bit; wider character buses are zero-extended.
  assign o_char = char_width'(w_ascii);

endmodule

`default_nettype wire

// File: rtl/hex_dump_formatter.sv
// ============================================================================
// Module      : hex_dump_formatter
// Description : Prints a stream of data words as ASCII hex text. Each word
//               becomes data_width/4 hex digits, most significant first,
//               followed by a space, or by CR LF after the last word of a
//               line. Output is a valid/ready character stream suitable
//               for a UART transmitter.
// Ports       : clk        in   1           clock, rising edge
//               reset_n    in   1           asynchronous active-low reset
//               in_valid   in   1           input word offered
//               in_ready   out  1           word accepted this cycle
//               in_data    in   data_width  word to print
//               out_valid  out  1           out_char is valid
//               out_ready  in   1           character sink accepts
//               out_char   out  char_width  ASCII character
//               busy       out  1           formatter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_dump_formatter
  import boot_hex_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int char_width     = 8,
  parameter int words_per_line = 4,
  parameter bit uppercase      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [char_width-1:0] out_char,
  output logic                  busy
);

  localparam int c_NIBBLES = data_width / 4;
  localparam int c_NIB_W   = clog2_min1(c_NIBBLES);
  localparam int c_WIL_W   = clog2_min1(words_per_line);

  localparam logic [c_NIB_W-1:0] c_LAST_NIB  = c_NIB_W'(c_NIBBLES - 1);
  localparam logic [c_WIL_W-1:0] c_LAST_WORD = c_WIL_W'(words_per_line - 1);

  generate
    if ((data_width < 4) || ((data_width % 4) != 0)) begin : g_bad_width
      $error("hex_dump_formatter: data_width must be a multiple of 4, at least 4");
    end
    if (words_per_line < 1) begin : g_bad_wpl
      $error("hex_dump_formatter: words_per_line must be at least 1");
    end
  endgenerate

  fmt_state_e              r_state;
  logic [data_width-1:0]   r_shift;
  logic [c_NIB_W-1:0]      r_nib_cnt;
  logic [c_WIL_W-1:0]      r_wil_cnt;
  logic                    r_out_valid;
  logic [char_width-1:0]   r_out_char;

  logic [data_width-1:0]   w_shifted;
  logic [3:0]              w_nib_sel;
  logic [char_width-1:0]   w_hex_char;
  logic                    w_xfer;

  // Outputs are registered, so the character register is loaded with the
  // digit that will be on display next. In IDLE that is the top nibble of
  // the incoming word; in NIBBLE it is the top nibble after this shift.
  assign w_shifted = r_shift << 4;
  assign w_nib_sel = (r_state == ST_IDLE) ? in_data[data_width-1 -: 4]
                                          : w_shifted[data_width-1 -: 4];

  nibble_to_hex_char #(
    .char_width (char_width),
    .uppercase  (uppercase)
  ) u_hex (
    .i_nibble (w_nib_sel),
    .o_char   (w_hex_char)
  );

  assign w_xfer = r_out_valid & out_ready;

  // Depends on state only, never on out_ready.
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_nib_cnt   <= '0;
      r_wil_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shift     <= in_data;
            r_nib_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_out_char  <= w_hex_char;
            r_state     <= ST_NIBBLE;
          end
        end

        ST_NIBBLE: begin
          if (w_xfer) begin
            r_shift   <= w_shifted;
            r_nib_cnt <= r_nib_cnt + 1'b1;
            if (r_nib_cnt == c_LAST_NIB) begin
              // Word finished: separator depends on position in the line.
              if (r_wil_cnt == c_LAST_WORD) begin
                r_wil_cnt  <= '0;
                r_out_char <= char_width'(CHAR_CR);
                r_state    <= ST_CR;
              end else begin
                r_wil_cnt  <= r_wil_cnt + 1'b1;
                r_out_char <= char_width'(CHAR_SP);
                r_state    <= ST_SPACE;
              end
            end else begin
              r_out_char <= w_hex_char;
            end
          end
        end

        ST_SPACE: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_state     <= ST_IDLE;
          end
        end

        ST_CR: begin
          if (w_xfer) begin
            r_out_char <= char_width'(CHAR_LF);
            r_state    <= ST_LF;
          end
        end

        ST_LF: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_out_char  <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
